rolling_scanner: RTL and testbench
==================================

Name: rolling_scanner

Overview:
- Upstream stage of the code-to-segment decoder in the rolling 7-segment display.
- Holds a message of 5-bit character codes and scrolls it across DIGITS display positions at a slow rate.
- Time-multiplexes the digits at a fast scan rate.
- Each cycle emits the code for the currently lit digit plus the active-low anode select; the code feeds the decoder directly.

Parameters:
- DIGITS, 8, number of physical digits; 2..16.
- MSG_LEN, 16, message buffer depth in codes; power of two, >= 2.
- SCAN_DIV, 100000, clock cycles each digit stays lit; >= 2.
- SHIFT_DIV, 50000000, clock cycles per one-position scroll step; >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = scrolling advances; 0 = scroll frozen, scanning continues.
- wr_en  in  1  message buffer write strobe.
- wr_addr  in  log2(MSG_LEN)  write address.
- wr_code  in  5  code to write (0 = blank).
- len  in  log2(MSG_LEN)+1  active message length.
- code  out  5  code for the currently lit digit, to the decoder.
- an  out  DIGITS  active-low one-hot anode select.
- offset  out  log2(MSG_LEN)  current scroll position.
- wrap  out  1  one-cycle pulse when offset wraps to 0.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - scan counter, shift counter, digit index, offset = 0; wrap = 0; code = 0.
  - an = all ones except an[0] = 0.
  - all MSG_LEN buffer entries cleared to 0.
  - Reset mid-operation has the same effect, including clearing the buffer.
- Effective length L:
  - len = 0: blank mode; code = 0 for every digit.
  - len > MSG_LEN: L = MSG_LEN.
  - otherwise L = len.
- Buffer write: on wr_en=1, buf[wr_addr] = wr_code at that edge. A write is allowed at any time, including while its entry is displayed.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the digit index k advances (DIGITS-1 wraps to 0).
  - an[k] = 0, all other an bits = 1.
  - an[0] is the rightmost digit; an[DIGITS-1] is the leftmost.
- Code mapping:
  - Position p = DIGITS-1-k, so the leftmost digit shows msg[offset].
  - code = buf[(offset + p) mod L]; the mod is exact for every L, including L < DIGITS, where the message repeats across the display.
- Output timing:
  - code and an are registered and update on the same edge, so they never disagree.
  - code is recomputed every cycle. A buffer write, len change or offset change at edge t appears on code at edge t+1.
- Scroll:
  - run=1: shift counter counts 0..SHIFT_DIV-1.
  - At terminal count: offset = offset+1, or 0 if offset+1 >= L. wrap = 1 for exactly that one cycle when the result is 0 by wraparound.
  - run=0: shift counter and offset hold.
  - Blank mode: offset held at 0, no wrap pulse.
- Length change: if offset >= L after len changes, offset is forced to 0 on the next edge with no wrap pulse. This takes priority over a coincident scroll step.
- Simultaneous events:
  - A scroll step and a digit advance on the same edge: both take effect, and code reflects the new offset and new index together.
  - A write and a scroll step on the same edge: both take effect.
- Counter widths are sized from their parameters; no overflow is possible.

Test Plan:
Bench parameters: DIGITS=4, MSG_LEN=8, SCAN_DIV=4, SHIFT_DIV=64.
1. Reset: hold rst 2 cycles, then release. Required after release:
   - an=4'b1110, code=0, offset=0, wrap=0.
   - an rotates 1110→1101→1011→0111 every 4 cycles; code stays 0 throughout.
2. Static message, run=0: write codes 1,2,3,3,4 ("hello") to addresses 0..4, set len=5.
   - an=0111→code 1; 1011→2; 1101→3; 1110→3.
   - offset stays 0 for 500 cycles.
3. Scrolling, run=1 from case 2:
   - After 64 cycles offset=1; leftmost digit shows 2, rightmost shows 4.
   - After 320 cycles total, wrap pulses high for exactly 1 cycle and offset=0.
   - Then drop run to 0: offset frozen.
4. Short message: len=2 with buf[0]=1, buf[1]=2, offset=0 → digits left-to-right show 1,2,1,2.
   - After one scroll step they show 2,1,2,1.
5. Length boundaries:
   - With offset=4, set len from 5 to 3 → offset=0 on the next edge, wrap stays 0.
   - len=0 → all codes 0.
   - len=12 → behaves as L=8; the wrap period is 8 steps.
6. Live write and reset:
   - Write buf[0]=9 while the leftmost digit is lit at offset 0 → code=9 one cycle later.
   - Assert rst mid-scroll → all buffer entries read back as code 0 and outputs return to reset values.

Source files
------------

// File: rtl/rolling_scanner.sv
// Upstream stage of the rolling 7-segment display. It holds a message of 5-bit codes,
// scrolls it across DIGITS positions and time-multiplexes the digits with an active-low anode.
module rolling_scanner #(
    parameter int DIGITS    = 8,
    parameter int MSG_LEN   = 16,
    parameter int SCAN_DIV  = 100000,
    parameter int SHIFT_DIV = 50000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
    input  logic [4:0]                   wr_code,
    input  logic [$clog2(MSG_LEN):0]     len,
    output logic [4:0]                   code,
    output logic [DIGITS-1:0]            an,
    output logic [$clog2(MSG_LEN)-1:0]   offset,
    output logic                         wrap
);

    localparam int AW  = $clog2(MSG_LEN);
    localparam int LW  = AW + 1;
    localparam int DW  = $clog2(DIGITS);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int SHW = $clog2(SHIFT_DIV);
    localparam int SW  = $clog2(MSG_LEN + DIGITS) + 1;

    logic [SCW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [SHW-1:0]    shift_cnt_q, shift_cnt_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [AW-1:0]     offset_q, offset_d;
    logic              wrap_q, wrap_d;
    logic [4:0]        code_q, code_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [4:0]        msg_q [MSG_LEN];

    logic              blank;
    logic              scan_tc;
    logic              shift_tc;
    logic [LW-1:0]     eff_len;
    logic [LW-1:0]     div_len;
    logic [SW-1:0]     pos_sum;
    logic [AW-1:0]     rd_idx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        blank    = (len == '0);
        eff_len  = (len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : len;
        div_len  = blank ? LW'(1) : eff_len;
        scan_tc  = (scan_cnt_q == SCW'(SCAN_DIV - 1));
        shift_tc = (shift_cnt_q == SHW'(SHIFT_DIV - 1));

        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_tc) begin
            digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
        end

        shift_cnt_d = shift_cnt_q;
        if (run) begin
            shift_cnt_d = shift_tc ? '0 : shift_cnt_q + 1'b1;
        end

        // An out-of-range offset after a length change is snapped back silently and
        // overrides any scroll step landing on the same edge.
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (blank || (LW'(offset_q) >= eff_len)) begin
            offset_d = '0;
        end else if (run && shift_tc) begin
            if (LW'(offset_q) + 1'b1 >= eff_len) begin
                offset_d = '0;
                wrap_d   = 1'b1;
            end else begin
                offset_d = offset_q + 1'b1;
            end
        end

        // The leftmost digit (highest index) shows msg[offset]; the exact modulo lets
        // short messages repeat across the display.
        pos_sum = SW'(offset_q) + SW'(DIGITS - 1) - SW'(digit_q);
        rd_idx  = AW'(pos_sum % SW'(div_len));
        code_d  = blank ? 5'd0 : msg_q[rd_idx];
        an_d    = ~(DIGITS'(1) << digit_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            shift_cnt_q <= '0;
            digit_q     <= '0;
            offset_q    <= '0;
            wrap_q      <= 1'b0;
            code_q      <= 5'd0;
            an_q        <= ~DIGITS'(1);
            // NOTE: the message store is cleared by reset, so it is built from flops rather than RAM.
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= 5'd0;
            end
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            shift_cnt_q <= shift_cnt_d;
            digit_q     <= digit_d;
            offset_q    <= offset_d;
            wrap_q      <= wrap_d;
            code_q      <= code_d;
            an_q        <= an_d;
            if (wr_en) begin
                msg_q[wr_addr] <= wr_code;
            end
        end
    end

    assign code   = code_q;
    assign an     = an_q;
    assign offset = offset_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_rolling_scanner.sv
// Bench for rolling_scanner: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model derived from cycle counts and modulo arithmetic.
module tb_rolling_scanner;

    localparam int DIGITS    = 4;
    localparam int MSG_LEN   = 8;
    localparam int SCAN_DIV  = 4;
    localparam int SHIFT_DIV = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_code;
    logic [3:0] len;
    logic [4:0] code;
    logic [3:0] an;
    logic [2:0] offset;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: cycles since reset, run-cycles since reset, scroll position.
    logic [4:0] m_buf [MSG_LEN];
    int         m_cyc   = 0;
    int         m_shift = 0;
    int         m_off   = 0;
    logic       m_wrap  = 1'b0;
    logic [4:0] exp_code = 5'd0;
    logic [3:0] exp_an   = 4'b1110;

    logic [4:0] hello [5] = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd4};

    rolling_scanner #(
        .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV), .SHIFT_DIV(SHIFT_DIV)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_code(wr_code), .len(len), .code(code), .an(an), .offset(offset), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int eff_len(input logic [3:0] l);
        if (l > 4'(MSG_LEN)) return MSG_LEN;
        return int'(l);
    endfunction

    // Expected code on the lit digit from a left-to-right table (c0 = leftmost).
    function automatic logic [4:0] table_code(input logic [3:0] a, input logic [4:0] c0,
                                               input logic [4:0] c1, input logic [4:0] c2,
                                               input logic [4:0] c3);
        case (a)
            4'b0111: return c0;
            4'b1011: return c1;
            4'b1101: return c2;
            4'b1110: return c3;
            default: return 5'h1f;
        endcase
    endfunction

    // Model reaction to one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        int L;
        int k;
        L = eff_len(len);
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 5'd0;
            m_cyc    = 0;
            m_shift  = 0;
            m_off    = 0;
            m_wrap   = 1'b0;
            exp_code = 5'd0;
            exp_an   = 4'b1110;
        end else begin
            k        = (m_cyc / SCAN_DIV) % DIGITS;
            exp_an   = 4'hf;
            exp_an[k] = 1'b0;
            exp_code = (L == 0) ? 5'd0 : m_buf[(m_off + DIGITS - 1 - k) % L];
            if (wr_en) m_buf[wr_addr] = wr_code;
            m_cyc++;
            m_wrap = 1'b0;
            if (L == 0 || m_off >= L) begin
                m_off = 0;
            end else if (run && (m_shift % SHIFT_DIV) == SHIFT_DIV - 1) begin
                if (m_off + 1 >= L) begin
                    m_off  = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_off = m_off + 1;
                end
            end
            if (run) m_shift++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b want 1110", an); end
        n_checks++; if (code !== 5'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", code); end
        n_checks++; if (offset !== 3'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", offset); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (an !== exp_an) begin n_fail++; $display("FAIL reset_rotate cyc %0d: an got %b want %b", i, an, exp_an); end
            n_checks++;
            if (code !== 5'd0) begin n_fail++; $display("FAIL reset_blank cyc %0d: code got %0d want 0", i, code); end
        end
    endtask

    task automatic test_static();
        logic [4:0] want;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_code = hello[i];
            tick();
        end
        wr_en = 1'b0;
        len = 4'd5;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            want = table_code(an, 5'd1, 5'd2, 5'd3, 5'd3);
            n_checks++;
            if (code !== want) begin n_fail++; $display("FAIL static_code an=%b: got %0d want %0d", an, code, want); end
        end
        for (int i = 0; i < 500; i++) begin
            tick();
            n_checks++;
            if (offset !== 3'd0) begin n_fail++; $display("FAIL static_offset cyc %0d: got %0d want 0", i, offset); end
        end
    endtask

    task automatic test_scroll();
        run = 1'b1;
        for (int i = 1; i <= 320; i++) begin
            tick();
            n_checks++;
            if (code !== exp_code || an !== exp_an || offset !== 3'(m_off) || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL scroll_model step %0d: code=%0d an=%b off=%0d wrap=%b want code=%0d an=%b off=%0d wrap=%b",
                         i, code, an, offset, wrap, exp_code, exp_an, m_off, m_wrap);
            end
            if (i == 63) begin
                n_checks++; if (offset !== 3'd0) begin n_fail++; $display("FAIL scroll_before_step: offset %0d want 0", offset); end
            end
            if (i == 64) begin
                n_checks++; if (offset !== 3'd1) begin n_fail++; $display("FAIL scroll_first_step: offset %0d want 1", offset); end
            end
            if (i >= 66 && i <= 81 && an == 4'b0111) begin
                n_checks++; if (code !== 5'd2) begin n_fail++; $display("FAIL scroll_leftmost: code %0d want 2", code); end
            end
            if (i >= 66 && i <= 81 && an == 4'b1110) begin
                n_checks++; if (code !== 5'd4) begin n_fail++; $display("FAIL scroll_rightmost: code %0d want 4", code); end
            end
            if (i == 319) begin
                n_checks++; if (wrap !== 1'b0 || offset !== 3'd4) begin n_fail++; $display("FAIL scroll_prewrap: wrap %b off %0d want 0/4", wrap, offset); end
            end
            if (i == 320) begin
                n_checks++; if (wrap !== 1'b1 || offset !== 3'd0) begin n_fail++; $display("FAIL scroll_wrap: wrap %b off %0d want 1/0", wrap, offset); end
            end
        end
        tick();
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL scroll_wrap_width: wrap %b want 0", wrap); end
        run = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_checks++;
            if (offset !== 3'd0 || wrap !== 1'b0) begin n_fail++; $display("FAIL scroll_frozen cyc %0d: off %0d wrap %b want 0/0", i, offset, wrap); end
        end
    endtask

    task automatic test_short_message();
        logic [4:0] want;
        int         budget;
        len = 4'd2;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            want = table_code(an, 5'd1, 5'd2, 5'd1, 5'd2);
            n_checks++;
            if (code !== want) begin n_fail++; $display("FAIL short_repeat an=%b: got %0d want %0d", an, code, want); end
        end
        run = 1'b1;
        budget = 0;
        while (offset == 3'd0 && budget < 100) begin tick(); budget++; end
        run = 1'b0;
        n_checks++;
        if (offset !== 3'd1) begin n_fail++; $display("FAIL short_step: offset %0d want 1 after %0d cycles", offset, budget); end
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            want = table_code(an, 5'd2, 5'd1, 5'd2, 5'd1);
            n_checks++;
            if (code !== want) begin n_fail++; $display("FAIL short_scrolled an=%b: got %0d want %0d", an, code, want); end
        end
    endtask

    task automatic test_length();
        int budget;
        int gap;
        int max_off;
        len = 4'd5;
        run = 1'b1;
        budget = 0;
        while (offset != 3'd4 && budget < 400) begin tick(); budget++; end
        run = 1'b0;
        n_checks++;
        if (offset !== 3'd4) begin n_fail++; $display("FAIL len_reach4: offset %0d want 4", offset); end
        len = 4'd3;
        tick();
        n_checks++;
        if (offset !== 3'd0 || wrap !== 1'b0) begin n_fail++; $display("FAIL len_shrink: off %0d wrap %b want 0/0", offset, wrap); end
        len = 4'd0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (code !== 5'd0 || offset !== 3'd0) begin n_fail++; $display("FAIL len_blank an=%b: code %0d off %0d want 0/0", an, code, offset); end
        end
        len = 4'd12;
        run = 1'b1;
        budget = 0;
        while (wrap !== 1'b1 && budget < 700) begin tick(); budget++; end
        n_checks++;
        if (wrap !== 1'b1) begin n_fail++; $display("FAIL len_long_first_wrap: no wrap within %0d cycles", budget); end
        gap = 0;
        max_off = 0;
        do begin
            tick();
            gap++;
            if (int'(offset) > max_off) max_off = int'(offset);
            n_checks++;
            if (code !== exp_code || offset !== 3'(m_off) || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL len_long_model: code=%0d off=%0d wrap=%b want code=%0d off=%0d wrap=%b",
                         code, offset, wrap, exp_code, m_off, m_wrap);
            end
        end while (wrap !== 1'b1 && gap < 700);
        run = 1'b0;
        n_checks++;
        if (gap !== 8 * SHIFT_DIV) begin n_fail++; $display("FAIL len_long_period: got %0d cycles want %0d", gap, 8 * SHIFT_DIV); end
        n_checks++;
        if (max_off !== 7) begin n_fail++; $display("FAIL len_long_max_offset: got %0d want 7", max_off); end
    endtask

    task automatic test_live_write_and_reset();
        int budget;
        budget = 0;
        while (an !== 4'b1110 && budget < 20) begin tick(); budget++; end
        budget = 0;
        while (an !== 4'b0111 && budget < 20) begin tick(); budget++; end
        n_checks++;
        if (an !== 4'b0111 || offset !== 3'd0) begin n_fail++; $display("FAIL live_setup: an %b off %0d want 0111/0", an, offset); end
        wr_en = 1'b1; wr_addr = 3'd0; wr_code = 5'd9;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (code !== 5'd1) begin n_fail++; $display("FAIL live_write_edge: code %0d want 1", code); end
        tick();
        n_checks++;
        if (code !== 5'd9 || an !== 4'b0111) begin n_fail++; $display("FAIL live_write_visible: code %0d an %b want 9/0111", code, an); end

        len = 4'd8;
        run = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (an !== 4'b1110 || code !== 5'd0 || offset !== 3'd0 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: an %b code %0d off %0d wrap %b want 1110/0/0/0", an, code, offset, wrap);
        end
        for (int i = 0; i < 8 * SHIFT_DIV + 16; i++) begin
            tick();
            n_checks++;
            if (code !== 5'd0) begin n_fail++; $display("FAIL reset_cleared_buf: off %0d an %b code %0d want 0", offset, an, code); end
        end
        run = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(999) == 0);
            run     = ($urandom_range(15) != 0);
            wr_en   = ($urandom_range(3) == 0);
            wr_addr = 3'($urandom_range(7));
            wr_code = 5'($urandom_range(31));
            if ($urandom_range(199) == 0) len = 4'($urandom_range(15));
            tick();
            n_checks++;
            if (code !== exp_code || an !== exp_an || offset !== 3'(m_off) || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL random_model cyc %0d len %0d: code=%0d an=%b off=%0d wrap=%b want code=%0d an=%b off=%0d wrap=%b",
                         i, len, code, an, offset, wrap, exp_code, exp_an, m_off, m_wrap);
            end
        end
        rst = 1'b0; run = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; wr_en = 1'b0;
        wr_addr = 3'd0; wr_code = 5'd0; len = 4'd0;
        for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 5'd0;
        test_reset();
        test_static();
        test_scroll();
        test_short_message();
        test_length();
        test_live_write_and_reset();
        len = 4'd5;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
